pwr_gate_ctrl: RTL
==================

PWR_GATE_CTRL -- requirements
Module: pwr_gate_ctrl

Interface
REQ-001 SHALL have parameter NUM_DOM, default 4: number of independently gated clock domains (1..16).
REQ-002 SHALL have parameter IDLE_CYCLES, default 16: consecutive wfi cycles required before gating (1..2^CNT_W-1).
REQ-003 SHALL have parameter WAKE_CYCLES, default 8: PLL relock/settle cycles before clock re-enable (1..2^CNT_W-1).
REQ-004 SHALL have parameter CNT_W, default 8: width of each per-domain counter.
REQ-005 SHALL have port clk, input, 1: single system clock; every register samples on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port wfi, input, NUM_DOM: per-domain idle request (CPU wait-for-interrupt).
REQ-008 SHALL have port wake, input, NUM_DOM: per-domain wake request (interrupt pending).
REQ-009 SHALL have port force_on, input, NUM_DOM: per-domain debug override that keeps the domain clocked.
REQ-010 SHALL have port clk_en, output, NUM_DOM: per-domain clock enable for the downstream glitch-free gate.
REQ-011 SHALL have port gated, output, NUM_DOM: high while the domain is in GATED.
REQ-012 SHALL have port wake_ack, output, NUM_DOM: one-cycle pulse when the domain returns to RUN from WAKE.
REQ-013 SHALL have port all_gated, output, 1: high when every domain is in GATED.
REQ-014 SHALL have port pll_bypass, output, 1: requests PLL bypass/latch while the whole system is idle.

Function
REQ-015 SHALL implement one independent 2-bit FSM per domain with states RUN=00, HYST=01, GATED=10, WAKE=11, plus a CNT_W-bit counter.
REQ-016 RUN: clk_en=1; on wfi=1 with wake=0 and force_on=0, go to GATED if IDLE_CYCLES=1, else to HYST with cnt=1.
REQ-017 HYST: clk_en=1; wfi=1, wake=0, force_on=0 -> cnt+1, and go to GATED when cnt+1 equals IDLE_CYCLES; any other input combination -> RUN, cnt=0.
REQ-018 Gating latency: wfi held high through N=IDLE_CYCLES consecutive sampling edges SHALL drop clk_en immediately after the Nth edge.
REQ-019 GATED: clk_en=0, gated=1; wake=1 or force_on=1 -> WAKE, cnt=0; wfi is ignored.
REQ-020 WAKE: clk_en=0, gated=0; each edge cnt+1; when cnt+1 equals WAKE_CYCLES -> RUN and wake_ack=1 for exactly that one cycle; wfi, wake and force_on are ignored.
REQ-021 Wake latency: wake sampled at edge m in GATED SHALL produce clk_en=1 and wake_ack=1 after edge m+WAKE_CYCLES.
REQ-022 Simultaneous wfi and wake (or force_on) in RUN or HYST: wake/force_on wins and the domain is in RUN after the edge.
REQ-023 force_on held high SHALL keep the domain in RUN; a gated domain SHALL still pass through WAKE before clocking resumes.
REQ-024 Counters SHALL never wrap; a counter is only ever compared against a parameter value smaller than 2^CNT_W.
REQ-025 all_gated SHALL be the AND over domains of (state==GATED), decoded directly from the state registers.
REQ-026 pll_bypass SHALL be a register with next value all_gated AND NOT OR-reduce(wake|force_on); it rises one cycle after all_gated and falls on the same edge at which a wake is sampled.
REQ-027 clk_en, gated and wake_ack SHALL be decoded from registered state with no combinational path from any input.
REQ-028 All domains SHALL be fully independent apart from the all_gated and pll_bypass outputs.

Reset
REQ-029 While reset=1, all domains SHALL be in RUN with cnt=0, clk_en all ones, gated=0, wake_ack=0, all_gated=0 and pll_bypass=0, regardless of clk.
REQ-030 Reset asserted during HYST or WAKE SHALL abandon the sequence; after release, the domain SHALL restart from RUN with no wake_ack pulse.
REQ-031 The first evaluation after reset release SHALL use the reset state; a wfi already high at release starts a fresh IDLE_CYCLES count.

Verification (NUM_DOM=2, IDLE_CYCLES=4, WAKE_CYCLES=3)
REQ-032 wfi[0]=1 for 4 edges -> clk_en[0]=0 and gated[0]=1 after edge 4; clk_en[1] stays 1; all_gated=0.
REQ-033 wfi[0]=1 for 3 edges, then 0 -> domain stays clocked, returns to RUN, and a new wfi needs 4 more edges.
REQ-034 Both domains gated -> all_gated=1 and pll_bypass=1 one cycle later; wake[1] pulse at edge m -> pll_bypass=0 at m, clk_en[1]=1 and wake_ack[1]=1 at m+3, and wake_ack[1]=0 at m+4.
REQ-035 wfi[0]=1 and wake[0]=1 on the same edge in RUN/HYST -> RUN, cnt=0, no gating.
REQ-036 force_on[0]=1 with wfi[0]=1 for 10 edges -> clk_en[0] stays 1 throughout; force_on while GATED -> 3-cycle WAKE, then RUN.
REQ-037 reset asserted mid-WAKE -> all outputs at reset values immediately (asynchronously); no wake_ack after release.

Source files
------------

// File: rtl/pwr_gate_ctrl.sv
// Per-domain clock-gating controller.
// Each domain counts consecutive idle (wfi) cycles before dropping its clock
// enable, then waits out a fixed PLL relock period after a wake request
// before clocking resumes. A system-wide PLL bypass request is raised
// while every domain is gated and nothing is asking to wake.
module pwr_gate_ctrl #(
  parameter int NUM_DOM     = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_DOM-1:0] wfi,
  input  logic [NUM_DOM-1:0] wake,
  input  logic [NUM_DOM-1:0] force_on,
  output logic [NUM_DOM-1:0] clk_en,
  output logic [NUM_DOM-1:0] gated,
  output logic [NUM_DOM-1:0] wake_ack,
  output logic               all_gated,
  output logic               pll_bypass
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    HYST  = 2'b01,
    GATED = 2'b10,
    WAKE  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] WAKE_LIM = CNT_W'(WAKE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q [NUM_DOM];
  state_t             state_d [NUM_DOM];
  logic [CNT_W-1:0]   cnt_q   [NUM_DOM];
  logic [CNT_W-1:0]   cnt_d   [NUM_DOM];
  logic [NUM_DOM-1:0] wake_ack_q, wake_ack_d;
  logic               pll_bypass_q, pll_bypass_d;

  // A domain may only start or continue its idle count when nothing is
  // asking it to stay awake; wake and force_on always win over wfi.
  logic [NUM_DOM-1:0] idle_req;
  logic [NUM_DOM-1:0] wake_req;

  assign idle_req = wfi & ~wake & ~force_on;
  assign wake_req = wake | force_on;

  // State, counter and registered-pulse storage for all domains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < NUM_DOM; d++) begin
        state_q[d] <= RUN;
        cnt_q[d]   <= '0;
      end
      wake_ack_q   <= '0;
      pll_bypass_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational next-state logic.
      for (int d = 0; d < NUM_DOM; d++) begin
        state_q[d] <= state_d[d];
        cnt_q[d]   <= cnt_d[d];
      end
      wake_ack_q   <= wake_ack_d;
      pll_bypass_q <= pll_bypass_d;
    end
  end

  // Per-domain next-state and counter logic.
  always_comb begin
    for (int d = 0; d < NUM_DOM; d++) begin
      // NOTE: every target gets a hold/default value before the case so no
      // path through the branches can infer a latch.
      state_d[d]    = state_q[d];
      cnt_d[d]      = cnt_q[d];
      wake_ack_d[d] = 1'b0;
      unique case (state_q[d])
        RUN: begin
          if (idle_req[d]) begin
            if (IDLE_LIM == CNT_ONE) begin
              state_d[d] = GATED;
              cnt_d[d]   = '0;
            end else begin
              state_d[d] = HYST;
              cnt_d[d]   = CNT_ONE;
            end
          end
        end
        HYST: begin
          if (idle_req[d]) begin
            if (cnt_q[d] + CNT_ONE == IDLE_LIM) begin
              state_d[d] = GATED;
              cnt_d[d]   = '0;
            end else begin
              cnt_d[d]   = cnt_q[d] + CNT_ONE;
            end
          end else begin
            state_d[d] = RUN;
            cnt_d[d]   = '0;
          end
        end
        GATED: begin
          if (wake_req[d]) begin
            state_d[d] = WAKE;
            cnt_d[d]   = '0;
          end
        end
        WAKE: begin
          // The relock period runs to completion regardless of inputs.
          if (cnt_q[d] + CNT_ONE == WAKE_LIM) begin
            state_d[d]    = RUN;
            cnt_d[d]      = '0;
            wake_ack_d[d] = 1'b1;
          end else begin
            cnt_d[d]      = cnt_q[d] + CNT_ONE;
          end
        end
        default: begin
          state_d[d] = RUN;
          cnt_d[d]   = '0;
        end
      endcase
    end
  end

  // Output decode straight from the state registers (no input paths).
  always_comb begin
    for (int d = 0; d < NUM_DOM; d++) begin
      clk_en[d] = (state_q[d] == RUN) || (state_q[d] == HYST);
      gated[d]  = (state_q[d] == GATED);
    end
  end

  assign all_gated  = &gated;
  assign wake_ack   = wake_ack_q;
  assign pll_bypass = pll_bypass_q;

  // Bypass drops on the very edge a wake is sampled, before any domain
  // has left GATED, so the PLL is relocking during the WAKE period.
  assign pll_bypass_d = all_gated & ~(|wake_req);

endmodule
